// File: rtl/riscv_idu_fifo.sv
// Decode-and-buffer stage between fetch and execute: decodes, sequence-tags and queues fetch words.
// Optional same-cycle bypass into an empty queue is enabled by defining RISCV_IDU_BYPASS_EN.

module riscv_decode (
    input  logic [31:0] data,
    output logic        defined,
    output logic        compressed
);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] f3c;

    assign opc = data[6:0];
    assign f3  = data[14:12];
    assign f7  = data[31:25];
    assign f3c = data[15:13];

    // RV32IC without floating point; the all-zero halfword is the canonical illegal encoding.
    always_comb begin
        compressed = (data[1:0] != 2'b11);
        defined    = 1'b0;
        if (compressed) begin
            case (data[1:0])
                2'b00: defined = (f3c == 3'b000) ? (data[12:5] != 8'd0)
                               : (f3c == 3'b010) || (f3c == 3'b110);
                2'b01: defined = 1'b1;
                default: defined = (f3c == 3'b000) || (f3c == 3'b010) ||
                                   (f3c == 3'b100) || (f3c == 3'b110);
            endcase
        end else begin
            case (opc)
                7'b0110111, 7'b0010111, 7'b1101111, 7'b0001111: defined = 1'b1;
                7'b1100111: defined = (f3 == 3'b000);
                7'b1100011: defined = (f3 != 3'b010) && (f3 != 3'b011);
                7'b0000011: defined = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
                7'b0100011: defined = (f3 <= 3'b010);
                7'b0010011: begin
                    if (f3 == 3'b001)      defined = (f7 == 7'b0000000);
                    else if (f3 == 3'b101) defined = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    else                   defined = 1'b1;
                end
                7'b0110011: defined = (f7 == 7'b0000000) ||
                                      ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                7'b1110011: begin
                    if (f3 == 3'b000)      defined = (data[31:7] == 25'd0) || (data[31:7] == 25'h0002000);
                    else                   defined = (f3 != 3'b100);
                end
                default: defined = 1'b0;
            endcase
        end
    end
endmodule

module riscv_idu_fifo #(
    parameter int DEPTH  = 4,
    parameter int SEQ_W  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         ifu_vld,
    output logic                         ifu_rdy,
    input  logic [ADDR_W-1:0]            ifu_addr,
    input  logic [31:0]                  ifu_data,
    output logic                         idu_vld,
    input  logic                         idu_rdy,
    output logic [SEQ_W-1:0]             idu_seq,
    output logic [ADDR_W-1:0]            idu_addr,
    output logic [31:0]                  idu_data,
    output logic                         idu_defined,
    output logic                         idu_compressed,
    output logic [$clog2(DEPTH+1)-1:0]   idu_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    // Handshakes: a word moves only when valid and ready are both high in the same cycle and
    // flush is low; ready never depends on valid on either side.

    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [SEQ_W-1:0]  seq_ctr, seq_next;
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [31:0]       mem_data [DEPTH];
    logic              mem_def  [DEPTH];
    logic              mem_comp [DEPTH];

    logic dec_defined, dec_compressed;
    logic enq, enq_wr, deq_q, byp_take;

    riscv_decode u_decode (
        .data       (ifu_data),
        .defined    (dec_defined),
        .compressed (dec_compressed)
    );

    assign seq_next  = seq_ctr + SEQ_W'(1);
    assign ifu_rdy   = (count < FULL);
    assign idu_count = count;
    assign enq       = ifu_vld & ifu_rdy & ~flush;
    assign deq_q     = (count != '0) & idu_rdy & ~flush;
    assign enq_wr    = enq & ~byp_take;

`ifdef RISCV_IDU_BYPASS_EN
    logic byp;

    // An empty queue presents the live fetch word; it is only written if the consumer stalls.
    assign byp      = (count == '0) & ifu_vld & ~flush;
    assign byp_take = byp & idu_rdy;
    assign idu_vld  = (count != '0) | byp;

    always_comb begin
        if (byp) begin
            idu_seq        = seq_next;
            idu_addr       = ifu_addr;
            idu_data       = ifu_data;
            idu_defined    = dec_defined;
            idu_compressed = dec_compressed;
        end else begin
            idu_seq        = mem_seq[rd_ptr];
            idu_addr       = mem_addr[rd_ptr];
            idu_data       = mem_data[rd_ptr];
            idu_defined    = mem_def[rd_ptr];
            idu_compressed = mem_comp[rd_ptr];
        end
    end
`else
    assign byp_take       = 1'b0;
    assign idu_vld        = (count != '0);
    assign idu_seq        = mem_seq[rd_ptr];
    assign idu_addr       = mem_addr[rd_ptr];
    assign idu_data       = mem_data[rd_ptr];
    assign idu_defined    = mem_def[rd_ptr];
    assign idu_compressed = mem_comp[rd_ptr];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            seq_ctr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_seq[i]  <= '0;
                mem_addr[i] <= '0;
                mem_data[i] <= '0;
                mem_def[i]  <= 1'b0;
                mem_comp[i] <= 1'b0;
            end
        end else if (flush) begin
            // Sequence counter survives a flush so numbers stay unique downstream.
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (enq) seq_ctr <= seq_next;
            if (enq_wr) begin
                mem_seq[wr_ptr]  <= seq_next;
                mem_addr[wr_ptr] <= ifu_addr;
                mem_data[wr_ptr] <= ifu_data;
                mem_def[wr_ptr]  <= dec_defined;
                mem_comp[wr_ptr] <= dec_compressed;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (deq_q) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq_wr, deq_q})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_idu_fifo.sv
// Directed bench for riscv_idu_fifo: vector table for single-cycle behaviour plus hand sequences
// for streaming, flush, reset override and (when RISCV_IDU_BYPASS_EN is defined) the bypass path.

module tb_riscv_idu_fifo;
    localparam int DEPTH  = 4;
    localparam int SEQ_W  = 64;
    localparam int ADDR_W = 32;
    localparam logic [31:0] A0 = 32'h8000_0000;

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic                       flush = 1'b0;
    logic                       ifu_vld = 1'b0;
    logic                       ifu_rdy;
    logic [ADDR_W-1:0]          ifu_addr = '0;
    logic [31:0]                ifu_data = '0;
    logic                       idu_vld;
    logic                       idu_rdy = 1'b0;
    logic [SEQ_W-1:0]           idu_seq;
    logic [ADDR_W-1:0]          idu_addr;
    logic [31:0]                idu_data;
    logic                       idu_defined;
    logic                       idu_compressed;
    logic [$clog2(DEPTH+1)-1:0] idu_count;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_idu_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .ifu_vld        (ifu_vld),
        .ifu_rdy        (ifu_rdy),
        .ifu_addr       (ifu_addr),
        .ifu_data       (ifu_data),
        .idu_vld        (idu_vld),
        .idu_rdy        (idu_rdy),
        .idu_seq        (idu_seq),
        .idu_addr       (idu_addr),
        .idu_data       (idu_data),
        .idu_defined    (idu_defined),
        .idu_compressed (idu_compressed),
        .idu_count      (idu_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        bit          fl;
        bit          iv;
        logic [31:0] a;
        logic [31:0] d;
        bit          rd;
        bit          e_irdy;
        bit          e_vld;
        int          e_cnt;
        longint      e_seq;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        bit          e_def;
        bit          e_comp;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(bit rst, bit fl, bit iv, logic [31:0] a, logic [31:0] d, bit rd,
                                bit e_irdy, bit e_vld, int e_cnt, longint e_seq,
                                logic [31:0] e_addr, logic [31:0] e_data, bit e_def, bit e_comp);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.a = a; v.d = d; v.rd = rd;
        v.e_irdy = e_irdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_seq = e_seq;
        v.e_addr = e_addr; v.e_data = e_data; v.e_def = e_def; v.e_comp = e_comp;
        return v;
    endfunction

    function automatic logic [31:0] addi(int k);
        return 32'h0000_0013 | (32'(k) << 20);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reset is held for one edge with a handshake and flush pending, which it must override.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; flush = 1'b1; ifu_vld = 1'b1; ifu_addr = 32'h1234_5678;
        ifu_data = 32'h0000_0013; idu_rdy = 1'b1;
        @(negedge clock);
        reset = 1'b0; flush = 1'b0; ifu_vld = 1'b0; idu_rdy = 1'b0;
    endtask

    task automatic check_zero(string tag);
        #1;
        check({tag, ".ifu_rdy"}, 64'(ifu_rdy), 64'd1);
        check({tag, ".idu_vld"}, 64'(idu_vld), 64'd0);
        check({tag, ".count"},   64'(idu_count), 64'd0);
        check({tag, ".seq"},     idu_seq, 64'd0);
        check({tag, ".addr"},    64'(idu_addr), 64'd0);
        check({tag, ".data"},    64'(idu_data), 64'd0);
        check({tag, ".def"},     64'(idu_defined), 64'd0);
        check({tag, ".comp"},    64'(idu_compressed), 64'd0);
    endtask

    task automatic apply(vec_t v, string tag);
        if (v.rst) do_reset();
        @(negedge clock);
        flush = v.fl; ifu_vld = v.iv; ifu_addr = v.a; ifu_data = v.d; idu_rdy = v.rd;
        #1;
        check({tag, ".ifu_rdy"}, 64'(ifu_rdy), 64'(v.e_irdy));
        check({tag, ".idu_vld"}, 64'(idu_vld), 64'(v.e_vld));
        check({tag, ".count"},   64'(idu_count), 64'(v.e_cnt));
        if (v.e_vld) begin
            check({tag, ".seq"},  idu_seq, 64'(v.e_seq));
            check({tag, ".addr"}, 64'(idu_addr), 64'(v.e_addr));
            check({tag, ".data"}, 64'(idu_data), 64'(v.e_data));
            check({tag, ".def"},  64'(idu_defined), 64'(v.e_def));
            check({tag, ".comp"}, 64'(idu_compressed), 64'(v.e_comp));
        end
    endtask

    initial begin
        do_reset();
        check_zero("reset0");

`ifndef RISCV_IDU_BYPASS_EN
        // Single word, one-cycle latency.
        tab.push_back(mk(1,0,1,A0,addi(0),1,      1,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,1,1, 1,A0,addi(0),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,0,0, 0,0,0,0,0));
        // Backpressure: fill, stall the fifth word, then drain.
        tab.push_back(mk(1,0,1,A0+4,addi(1),0,    1,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,1,A0+8,addi(2),0,    1,1,1, 1,A0+4,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+12,addi(3),0,   1,1,2, 1,A0+4,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+16,addi(4),0,   1,1,3, 1,A0+4,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+20,addi(5),0,   0,1,4, 1,A0+4,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+20,addi(5),1,   0,1,4, 1,A0+4,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+20,addi(5),1,   1,1,3, 2,A0+8,addi(2),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,1,3, 3,A0+12,addi(3),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,1,2, 4,A0+16,addi(4),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,1,1, 5,A0+20,addi(5),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,0,0, 0,0,0,0,0));
        // Flush with three queued and a word offered; numbering continues at 4.
        tab.push_back(mk(1,0,1,A0,addi(1),0,      1,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,1,A0+4,addi(2),0,    1,1,1, 1,A0,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+8,addi(3),0,    1,1,2, 1,A0,addi(1),1,0));
        tab.push_back(mk(0,1,1,A0+12,addi(7),1,   1,1,3, 1,A0,addi(1),1,0));
        tab.push_back(mk(0,0,1,A0+16,addi(8),1,   1,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,1,1, 4,A0+16,addi(8),1,0));
        tab.push_back(mk(0,0,0,0,0,1,             1,0,0, 0,0,0,0,0));
        // Undefined 32-bit word followed by C.LI.
        tab.push_back(mk(1,0,1,A0,32'h0000_FFFF,0,     1,0,0, 0,0,0,0,0));
        tab.push_back(mk(0,0,1,A0+4,32'h0000_4501,0,   1,1,1, 1,A0,32'h0000_FFFF,0,0));
        tab.push_back(mk(0,0,0,0,0,1,                  1,1,2, 1,A0,32'h0000_FFFF,0,0));
        tab.push_back(mk(0,0,0,0,0,1,                  1,1,1, 2,A0+4,32'h0000_4501,1,1));
        tab.push_back(mk(0,0,0,0,0,1,                  1,0,0, 0,0,0,0,0));

        foreach (tab[i]) apply(tab[i], $sformatf("vec%0d", i));

        // Streaming: one in, one out every cycle, pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            if (i == 0)
                apply(mk(1,0,1,A0,addi(0),1, 1,0,0, 0,0,0,0,0), "stream0");
            else
                apply(mk(0,0,1,A0+32'(4*i),addi(i),1, 1,1,1, longint'(i),A0+32'(4*(i-1)),addi(i-1),1,0),
                      $sformatf("stream%0d", i));
        end
        apply(mk(0,0,0,0,0,1, 1,1,1, 20,A0+32'(4*19),addi(19),1,0), "stream_last");
        apply(mk(0,0,0,0,0,1, 1,0,0, 0,0,0,0,0), "stream_empty");

        // Reset with two entries queued and a word offered.
        apply(mk(1,0,1,A0,addi(1),0,   1,0,0, 0,0,0,0,0), "rstq0");
        apply(mk(0,0,1,A0+4,addi(2),0, 1,1,1, 1,A0,addi(1),1,0), "rstq1");
        do_reset();
        check_zero("reset_busy");
        apply(mk(0,0,1,A0+8,addi(3),1, 1,0,0, 0,0,0,0,0), "rstq2");
        apply(mk(0,0,0,0,0,1,          1,1,1, 1,A0+8,addi(3),1,0), "rstq3");
`else
        // Bypass: empty queue with consumer ready presents and consumes the word in one cycle.
        apply(mk(0,0,1,A0,32'h0000_4501,1,   1,1,0, 1,A0,32'h0000_4501,1,1), "byp0");
        apply(mk(0,0,0,0,0,1,                1,0,0, 0,0,0,0,0), "byp1");
        // Consumer stalled: the bypassed word is also written and stays at the head.
        apply(mk(0,0,1,A0+4,32'h0000_FFFF,0, 1,1,0, 2,A0+4,32'h0000_FFFF,0,0), "byp2");
        apply(mk(0,0,0,0,0,0,                1,1,1, 2,A0+4,32'h0000_FFFF,0,0), "byp3");
        apply(mk(0,0,0,0,0,1,                1,1,1, 2,A0+4,32'h0000_FFFF,0,0), "byp4");
        apply(mk(0,0,0,0,0,1,                1,0,0, 0,0,0,0,0), "byp5");
        // Flush suppresses the bypass.
        apply(mk(0,1,1,A0+8,addi(1),1,       1,0,0, 0,0,0,0,0), "byp6");
        apply(mk(0,0,1,A0+12,addi(2),1,      1,1,0, 3,A0+12,addi(2),1,0), "byp7");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion before 200000");
        $fatal(1);
    end
endmodule
